// File: rtl/rh_intr.sv
// rh_intr: RH11 interrupt request sequencer. It watches CS1 and raises a BR request,
// completes the grant/ack handshake, supplies the vector and pulses rhIACK.
module rh_intr #(
    parameter int          BRLEV = 6,
    parameter logic [17:0] VECT  = 18'o000254
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        devRESET,
    input  logic        rhCLR,
    input  logic        devLOBYTE,
    input  logic [0:35] devDATAI,
    input  logic        rhcs1WRITE,
    input  logic [15:0] rhCS1,
    input  logic [7:4]  devINTA,
    output logic [7:4]  devINTR,
    output logic [17:0] devVECT,
    output logic        rhIACK,
    output logic [15:0] intrCNT,
    output logic        intrOVR
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, ACK = 2'd2;
    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_rdy_q, last_sc_q, ovr_q, ovr_d;
    logic        ie, rdy, sc, trig, clear, grant, unused;
    assign ie     = rhCS1[6];
    assign rdy    = rhCS1[7];
    assign sc     = rhCS1[15];
    assign clear  = devRESET | rhCLR;
    assign grant  = devINTA[BRLEV];
    assign unused = ^{devDATAI[0:27], devDATAI[30:35], rhCS1[14:8], rhCS1[5:0]};
    // devDATAI is big-endian: data bit n lives at devDATAI[35-n]
    assign trig = (ie & rdy & (~last_rdy_q | (sc & ~last_sc_q)))
                | (rhcs1WRITE & devLOBYTE & devDATAI[29] & devDATAI[28] & rdy);
    always_comb begin
        state_d = clear ? IDLE
                : (state_q == REQ) ? (grant ? ACK : (ie | trig) ? REQ : IDLE)
                : (trig ? REQ : IDLE);
        ovr_d   = ~clear & (ovr_q | ((state_q == REQ) & trig));
        cnt_d   = ((state_d == ACK) && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
    end
    always_comb begin
        devINTR        = '0;
        devINTR[BRLEV] = (state_q == REQ);
    end
    assign devVECT = (state_q == ACK) ? VECT : 18'd0;
    assign rhIACK  = (state_q == ACK);
    assign intrCNT = cnt_q;
    assign intrOVR = ovr_q;
    // history starts at 1 so the first cycle out of reset cannot see a false edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ovr_q      <= 1'b0;
            last_rdy_q <= 1'b1;
            last_sc_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ovr_q      <= ovr_d;
            last_rdy_q <= rdy;
            last_sc_q  <= sc;
        end
    end
endmodule

// File: tb/tb_rh_intr.sv
// tb_rh_intr: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_rh_intr;
    logic        clk = 1'b0;
    logic        rst, devRESET, rhCLR, devLOBYTE, rhcs1WRITE, rhIACK, intrOVR;
    logic [0:35] devDATAI;
    logic [15:0] rhCS1, intrCNT;
    logic [7:4]  devINTA, devINTR;
    logic [17:0] devVECT;
    logic [39:0] obs;
    int          vectors = 0;
    int          miscompares = 0;

    localparam logic [15:0] C_IE = 16'h0040, C_RDY = 16'h0080, C_SC = 16'h8000;

    rh_intr dut (
        .clk(clk), .rst(rst), .devRESET(devRESET), .rhCLR(rhCLR), .devLOBYTE(devLOBYTE),
        .devDATAI(devDATAI), .rhcs1WRITE(rhcs1WRITE), .rhCS1(rhCS1), .devINTA(devINTA),
        .devINTR(devINTR), .devVECT(devVECT), .rhIACK(rhIACK), .intrCNT(intrCNT), .intrOVR(intrOVR)
    );

    always #5 clk = ~clk;
    assign obs = {devINTR, devVECT, rhIACK, intrCNT, intrOVR};

    function automatic logic [39:0] e(input bit req, input bit ack, input int cnt, input bit ovr);
        return {req ? 4'b0100 : 4'b0000, ack ? 18'o000254 : 18'o0, ack, 16'(cnt), ovr};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input bit on);
        rhcs1WRITE = on;
        devLOBYTE  = on;
        devDATAI   = on ? 36'o300 : 36'o0;
    endtask

    task automatic test_reset();
        rst = 1'b1; devRESET = 0; rhCLR = 0; devINTA = 0; rhCS1 = 0;
        prog_write(0);
        cyc();
        vectors++; if (obs !== e(0, 0, 0, 0)) begin miscompares++; $display("FAIL reset obs=%h exp=%h", obs, e(0, 0, 0, 0)); end
        rst = 1'b0; rhCS1 = C_IE | C_RDY | C_SC;
        cyc();
        vectors++; if (obs !== e(0, 0, 0, 0)) begin miscompares++; $display("FAIL reset_no_spurious obs=%h exp=%h", obs, e(0, 0, 0, 0)); end
    endtask

    task automatic test_done();
        rhCS1 = C_IE;
        cyc();
        rhCS1 = C_IE | C_RDY;
        cyc();
        for (int i = 0; i < 4; i++) begin
            vectors++; if (obs !== e(1, 0, 0, 0)) begin miscompares++; $display("FAIL done_req[%0d] obs=%h exp=%h", i, obs, e(1, 0, 0, 0)); end
            cyc();
        end
        devINTA = 4'b0100;
        cyc();
        vectors++; if (obs !== e(0, 1, 1, 0)) begin miscompares++; $display("FAIL done_ack obs=%h exp=%h", obs, e(0, 1, 1, 0)); end
        devINTA = 0;
        cyc();
        vectors++; if (obs !== e(0, 0, 1, 0)) begin miscompares++; $display("FAIL done_idle obs=%h exp=%h", obs, e(0, 0, 1, 0)); end
    endtask

    task automatic test_program();
        rhCS1 = C_RDY;
        prog_write(1);
        cyc();
        prog_write(0);
        rhCS1 = C_IE | C_RDY;
        vectors++; if (obs !== e(1, 0, 1, 0)) begin miscompares++; $display("FAIL prog_req obs=%h exp=%h", obs, e(1, 0, 1, 0)); end
        devINTA = 4'b1000;
        cyc();
        vectors++; if (obs !== e(1, 0, 1, 0)) begin miscompares++; $display("FAIL prog_wrong_grant obs=%h exp=%h", obs, e(1, 0, 1, 0)); end
        devINTA = 0; rhCS1 = C_RDY;
        cyc();
        vectors++; if (obs !== e(0, 0, 1, 0)) begin miscompares++; $display("FAIL prog_withdraw obs=%h exp=%h", obs, e(0, 0, 1, 0)); end
    endtask

    task automatic test_attention_overrun();
        rhCS1 = C_IE | C_RDY;
        cyc();
        vectors++; if (obs !== e(0, 0, 1, 0)) begin miscompares++; $display("FAIL attn_quiet obs=%h exp=%h", obs, e(0, 0, 1, 0)); end
        rhCS1 = C_IE | C_RDY | C_SC;
        cyc();
        vectors++; if (obs !== e(1, 0, 1, 0)) begin miscompares++; $display("FAIL attn_req obs=%h exp=%h", obs, e(1, 0, 1, 0)); end
        prog_write(1);
        cyc();
        prog_write(0);
        vectors++; if (obs !== e(1, 0, 1, 1)) begin miscompares++; $display("FAIL attn_overrun obs=%h exp=%h", obs, e(1, 0, 1, 1)); end
        devINTA = 4'b0100;
        cyc();
        devINTA = 0;
        vectors++; if (obs !== e(0, 1, 2, 1)) begin miscompares++; $display("FAIL attn_ack obs=%h exp=%h", obs, e(0, 1, 2, 1)); end
        cyc();
        vectors++; if (obs !== e(0, 0, 2, 1)) begin miscompares++; $display("FAIL attn_single obs=%h exp=%h", obs, e(0, 0, 2, 1)); end
    endtask

    task automatic test_clear_vs_grant();
        prog_write(1);
        cyc();
        prog_write(0);
        vectors++; if (obs !== e(1, 0, 2, 1)) begin miscompares++; $display("FAIL clr_req obs=%h exp=%h", obs, e(1, 0, 2, 1)); end
        rhCLR = 1'b1; devINTA = 4'b0100;
        cyc();
        rhCLR = 1'b0; devINTA = 0;
        vectors++; if (obs !== e(0, 0, 2, 0)) begin miscompares++; $display("FAIL clr_beats_grant obs=%h exp=%h", obs, e(0, 0, 2, 0)); end
        cyc();
        vectors++; if (obs !== e(0, 0, 2, 0)) begin miscompares++; $display("FAIL clr_stays_idle obs=%h exp=%h", obs, e(0, 0, 2, 0)); end
    endtask

    task automatic test_reset_mid_ack();
        prog_write(1);
        cyc();
        prog_write(0);
        devINTA = 4'b0100;
        cyc();
        devINTA = 0;
        vectors++; if (obs !== e(0, 1, 3, 0)) begin miscompares++; $display("FAIL rst_ack obs=%h exp=%h", obs, e(0, 1, 3, 0)); end
        rst = 1'b1;
        prog_write(1);
        cyc();
        rst = 1'b0;
        prog_write(0);
        vectors++; if (obs !== e(0, 0, 0, 0)) begin miscompares++; $display("FAIL rst_mid_ack obs=%h exp=%h", obs, e(0, 0, 0, 0)); end
        cyc();
        vectors++; if (obs !== e(0, 0, 0, 0)) begin miscompares++; $display("FAIL rst_first_cycle obs=%h exp=%h", obs, e(0, 0, 0, 0)); end
    endtask

    task automatic test_saturation();
        int exp_cnt = 16'hFFFC;
        // preload the counter instead of spending 65k grants getting there
        force dut.cnt_q = 16'hFFFC;
        cyc();
        release dut.cnt_q;
        cyc();
        vectors++; if (obs !== e(0, 0, exp_cnt, 0)) begin miscompares++; $display("FAIL sat_preload obs=%h exp=%h", obs, e(0, 0, exp_cnt, 0)); end
        for (int i = 0; i < 5; i++) begin
            prog_write(1);
            cyc();
            prog_write(0);
            vectors++; if (obs !== e(1, 0, exp_cnt, 0)) begin miscompares++; $display("FAIL sat_req[%0d] obs=%h exp=%h", i, obs, e(1, 0, exp_cnt, 0)); end
            devINTA = 4'b0100;
            cyc();
            devINTA = 0;
            exp_cnt = (exp_cnt < 65535) ? exp_cnt + 1 : 65535;
            vectors++; if (obs !== e(0, 1, exp_cnt, 0)) begin miscompares++; $display("FAIL sat_ack[%0d] obs=%h exp=%h", i, obs, e(0, 1, exp_cnt, 0)); end
        end
    endtask

    task automatic test_random();
        bit pend = 0, ack = 0, ovr = 0, p_rdy = 1, p_sc = 1, trig, ie, rdy, sc, granted;
        int cnt = 0;
        rst = 1'b1;
        cyc();
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 99) == 0);
            devRESET   = ($urandom_range(0, 39) == 0);
            rhCLR      = ($urandom_range(0, 39) == 0);
            rhCS1      = 16'($urandom());
            rhcs1WRITE = ($urandom_range(0, 3) == 0);
            devLOBYTE  = 1'($urandom_range(0, 1));
            devDATAI   = 36'({$urandom(), $urandom()});
            devDATAI[28] = ($urandom_range(0, 3) != 0);
            devDATAI[29] = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: devINTA = 4'b0100;
                1: devINTA = 4'(1 << $urandom_range(0, 3));
                default: devINTA = 4'b0000;
            endcase
            ie = rhCS1[6]; rdy = rhCS1[7]; sc = rhCS1[15];
            trig = (ie && rdy && !p_rdy) || (ie && rdy && sc && !p_sc)
                || (rhcs1WRITE && devLOBYTE && devDATAI[29] && devDATAI[28] && rdy);
            if (rst) begin
                pend = 0; ack = 0; ovr = 0; cnt = 0; p_rdy = 1; p_sc = 1;
            end else begin
                if (devRESET || rhCLR) begin
                    pend = 0; ack = 0; ovr = 0;
                end else if (pend) begin
                    granted = devINTA[6];
                    if (trig) ovr = 1;
                    ack  = granted;
                    pend = !granted && (ie || trig);
                end else begin
                    pend = trig; ack = 0;
                end
                if (ack) cnt = (cnt < 65535) ? cnt + 1 : 65535;
                p_rdy = rdy; p_sc = sc;
            end
            cyc();
            vectors++; if (obs !== e(pend, ack, cnt, ovr)) begin miscompares++; $display("FAIL random[%0d] obs=%h exp=%h", i, obs, e(pend, ack, cnt, ovr)); end
        end
        rst = 1'b0; devRESET = 0; rhCLR = 0; devINTA = 0;
        prog_write(0);
    endtask

    initial begin
        test_reset();
        test_done();
        test_program();
        test_attention_overrun();
        test_clear_vs_grant();
        test_reset_mid_ack();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
